// File: rtl/lc3_mem_arbiter.sv
// LC-3 main memory sequencer: shares one multi-cycle memory port between the CPU and debug/loader requesters.
// Optional macro LC3_ARB_RR_EN selects round-robin arbitration; default is fixed priority dbg > cpu.
module lc3_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner_dbg
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
      $error("lc3_mem_arbiter: MEM_LAT must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              we_lat, we_lat_nxt;
  logic              grant, grant_dbg;
  logic              mem_en_nxt, mem_we_nxt, busy_nxt, owner_dbg_nxt;
  logic              cpu_ack_nxt, dbg_ack_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, cpu_rdata_nxt, dbg_rdata_nxt;

  assign grant = (state == IDLE) && (cpu_req || dbg_req);

`ifdef LC3_ARB_RR_EN
  // On a tie the port that was not granted last wins.
  logic last_dbg;

  assign grant_dbg = (cpu_req && dbg_req) ? !last_dbg : dbg_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dbg <= 1'b0;
    end else if (grant) begin
      last_dbg <= grant_dbg;
    end
  end
`else
  assign grant_dbg = dbg_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so each value below is what the port shows in the state being entered.
  always_comb begin
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    cpu_ack_nxt   = 1'b0;
    dbg_ack_nxt   = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    we_lat_nxt    = we_lat;
    owner_dbg_nxt = owner_dbg;
    cnt_nxt       = cnt;
    cpu_rdata_nxt = cpu_rdata;
    dbg_rdata_nxt = dbg_rdata;
    case (state)
      IDLE: begin
        if (grant) begin
          owner_dbg_nxt = grant_dbg;
          we_lat_nxt    = grant_dbg ? dbg_we    : cpu_we;
          mem_addr_nxt  = grant_dbg ? dbg_addr  : cpu_addr;
          mem_wdata_nxt = grant_dbg ? dbg_wdata : cpu_wdata;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = grant_dbg ? dbg_we    : cpu_we;
        end
      end
      ISSUE: cnt_nxt = CNT_INIT;
      WAIT: begin
        if (cnt == 4'd0) begin
          if (!we_lat) begin
            if (owner_dbg) dbg_rdata_nxt = mem_rdata;
            else           cpu_rdata_nxt = mem_rdata;
          end
          cpu_ack_nxt = !owner_dbg;
          dbg_ack_nxt = owner_dbg;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: ;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      busy      <= 1'b0;
      owner_dbg <= 1'b0;
      we_lat    <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      dbg_rdata <= dbg_rdata_nxt;
      cpu_ack   <= cpu_ack_nxt;
      dbg_ack   <= dbg_ack_nxt;
      busy      <= busy_nxt;
      owner_dbg <= owner_dbg_nxt;
      we_lat    <= we_lat_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter at MEM_LAT=3; memory model returns addr ^ 16'h2234 exactly MEM_LAT cycles after mem_en.
module tb_lc3_mem_arbiter;

  localparam int LAT = 3;
`ifdef LC3_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, rst;
  logic        cpu_req, cpu_we, cpu_ack, dbg_req, dbg_we, dbg_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_en, mem_we, busy, owner_dbg;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner_dbg(owner_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data is valid only in the cycle exactly LAT cycles after mem_en.
  logic        pend;
  logic [3:0]  mcnt;
  logic [15:0] paddr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0; mcnt <= 4'd0; paddr <= 16'h0;
    end else if (mem_en) begin
      pend <= 1'b1; mcnt <= 4'(LAT - 1); paddr <= mem_addr;
    end else if (pend) begin
      if (mcnt == 4'd0) pend <= 1'b0;
      else              mcnt <= mcnt - 4'd1;
    end
  end
  assign mem_rdata = (pend && mcnt == 4'd0) ? (paddr ^ 16'h2234) : 16'hDEAD;

  typedef struct { int cyc; logic port; logic [15:0] rdata; logic owner; } ack_t;
  typedef struct { int cyc; logic we; logic [15:0] addr; logic [15:0] wdata; } en_t;
  typedef struct {
    logic cr; logic cw; logic [15:0] ca; logic [15:0] cd;
    logic dr; logic dw; logic [15:0] da; logic [15:0] dd;
    logic exp_dbg; logic exp_we; logic [15:0] exp_addr; logic [15:0] exp_wdata; logic [15:0] exp_rdata;
  } vec_t;

  ack_t ack_q[$];
  en_t  en_q[$];
  logic busy_q[$];
  int   checks = 0, errors = 0, we_alone = 0;
  logic [15:0] m_cpu_rd = 16'h0, m_dbg_rd = 16'h0;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Samples one cycle per negedge starting with the current cycle (k=0); stops `tail` cycles after `want` acks.
  task automatic run(input string tag, input int max_cyc, input int want, input int tail,
                     input bit hold_c, input bit hold_d, input bit drop_all);
    int k, left;
    ack_q.delete(); en_q.delete(); busy_q.delete();
    k = 0; left = -1;
    while (k < max_cyc && left != 0) begin
      @(negedge clk);
      busy_q.push_back(busy);
      if (mem_en) en_q.push_back('{k, mem_we, mem_addr, mem_wdata});
      if (mem_we && !mem_en) we_alone++;
      if (cpu_ack) begin
        ack_q.push_back('{k, 1'b0, cpu_rdata, owner_dbg});
        if (hold_c) cpu_addr = cpu_addr + 16'd1;
        else        cpu_req = 1'b0;
        if (drop_all) dbg_req = 1'b0;
      end
      if (dbg_ack) begin
        ack_q.push_back('{k, 1'b1, dbg_rdata, owner_dbg});
        if (!hold_d) dbg_req = 1'b0;
        if (drop_all) cpu_req = 1'b0;
      end
      if (left > 0) left--;
      else if (left < 0 && ack_q.size() >= want) left = tail;
      k++;
    end
    chk({tag, "_ack_count"}, 64'(ack_q.size()), 64'(want));
  endtask

  initial begin
    int ncpu;
    logic exp_port;
    vecs[0] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0025, 16'h0400, 1'b1, 1'b1, 16'h0025, 16'h0400, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h2334};
    vecs[3] = '{1'b1, 1'b1, 16'h4000, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h4000, 16'hBEEF, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 16'h3001, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h2034};
    vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hDDCB};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000};

    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_cpu_rdata", cpu_rdata, 0);
    chk("reset_dbg_rdata", dbg_rdata, 0);
    chk("reset_acks", {cpu_ack, dbg_ack}, 0);
    chk("reset_mem_ctl", {mem_en, mem_we}, 0);
    chk("reset_mem_addr_wdata", {mem_addr, mem_wdata}, 0);
    chk("reset_busy_owner", {busy, owner_dbg}, 0);
    tick();

    // Single transactions: ack at LAT+2, one mem_en in cycle 1.
    for (int i = 0; i < 7; i++) begin
      cpu_req = vecs[i].cr; cpu_we = vecs[i].cw; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
      dbg_req = vecs[i].dr; dbg_we = vecs[i].dw; dbg_addr = vecs[i].da; dbg_wdata = vecs[i].dd;
      run($sformatf("v%0d", i), 40, 1, 4, 1'b0, 1'b0, 1'b1);
      chk($sformatf("v%0d_en_count", i), 64'(en_q.size()), 1);
      chk($sformatf("v%0d_en_cycle", i), 64'(en_q[0].cyc), 1);
      chk($sformatf("v%0d_mem_we", i), en_q[0].we, vecs[i].exp_we);
      chk($sformatf("v%0d_mem_addr", i), en_q[0].addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_mem_wdata", i), en_q[0].wdata, vecs[i].exp_wdata);
      chk($sformatf("v%0d_ack_cycle", i), 64'(ack_q[0].cyc), 64'(LAT + 2));
      chk($sformatf("v%0d_ack_port", i), ack_q[0].port, vecs[i].exp_dbg);
      chk($sformatf("v%0d_owner_dbg", i), ack_q[0].owner, vecs[i].exp_dbg);
      chk($sformatf("v%0d_busy", i), {busy_q[0], busy_q[1], busy_q[LAT + 2], busy_q[LAT + 3]}, 4'b0110);
      if (!vecs[i].exp_we) begin
        if (vecs[i].exp_dbg) m_dbg_rd = vecs[i].exp_rdata;
        else                 m_cpu_rd = vecs[i].exp_rdata;
      end
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, m_cpu_rd);
      chk($sformatf("v%0d_dbg_rdata", i), dbg_rdata, m_dbg_rd);
      tick();
    end

    // Both request together; loser is served right after, LAT+3 cycles later.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3001; dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0300;
    run("both", 80, 2, 3, 1'b0, 1'b0, 1'b0);
    exp_port = RR ? 1'b0 : 1'b1;
    chk("both_first_port", ack_q[0].port, exp_port);
    chk("both_second_port", ack_q[1].port, !exp_port);
    chk("both_first_cycle", 64'(ack_q[0].cyc), 64'(LAT + 2));
    chk("both_gap", 64'(ack_q[1].cyc - ack_q[0].cyc), 64'(LAT + 3));
    chk("both_en_count", 64'(en_q.size()), 2);
    m_cpu_rd = 16'h1235; m_dbg_rd = 16'h2134;
    chk("both_cpu_rdata", cpu_rdata, m_cpu_rd);
    chk("both_dbg_rdata", dbg_rdata, m_dbg_rd);
    tick();

    // Continuous requests from both ports: fixed priority starves cpu, round-robin alternates.
    cpu_req = 1; cpu_addr = 16'h3000; dbg_req = 1; dbg_addr = 16'h0025;
    run("cont", 200, 4, 0, 1'b1, 1'b1, 1'b0);
    cpu_req = 0; dbg_req = 0;
    ncpu = 0;
    for (int j = 0; j < 4; j++) begin
      exp_port = RR ? j[0] : 1'b1;
      chk($sformatf("cont%0d_port", j), ack_q[j].port, exp_port);
      chk($sformatf("cont%0d_cycle", j), 64'(ack_q[j].cyc), 64'(LAT + 2 + j * (LAT + 3)));
      if (exp_port) begin
        m_dbg_rd = 16'h2211;
      end else begin
        m_cpu_rd = (16'h3000 + 16'(ncpu)) ^ 16'h2234;
        ncpu++;
      end
      chk($sformatf("cont%0d_rdata", j), ack_q[j].rdata, exp_port ? m_dbg_rd : m_cpu_rd);
    end
    tick();

    // Reset asserted in WAIT of a cpu read: immediate clear, then restart from IDLE.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3001;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_rdata", {cpu_rdata, dbg_rdata}, 0);
    chk("rst_mid_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_mid_ctl", {cpu_ack, dbg_ack, busy, owner_dbg}, 0);
    @(posedge clk); #1 rst = 1'b0;
    run("rst_restart", 40, 1, 3, 1'b0, 1'b0, 1'b0);
    chk("rst_restart_ack_cycle", 64'(ack_q[0].cyc), 64'(LAT + 2));
    chk("rst_restart_rdata", cpu_rdata, 16'h1235);
    chk("rst_restart_dbg_rdata", dbg_rdata, 0);
    tick();

    // Back-to-back cpu reads holding req through the ack.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
    run("b2b", 80, 2, 0, 1'b1, 1'b0, 1'b0);
    cpu_req = 0;
    chk("b2b_first_cycle", 64'(ack_q[0].cyc), 64'(LAT + 2));
    chk("b2b_first_rdata", ack_q[0].rdata, 16'h1234);
    chk("b2b_gap", 64'(ack_q[1].cyc - ack_q[0].cyc), 64'(LAT + 3));
    chk("b2b_second_rdata", ack_q[1].rdata, 16'h1235);
    chk("b2b_second_en", 64'(en_q[1].cyc), 64'(ack_q[0].cyc + 2));
    chk("b2b_second_addr", en_q[1].addr, 16'h3001);
    repeat (3) tick();
    @(negedge clk);
    chk("b2b_idle_busy", busy, 0);
    tick();

    // A dbg request raised mid-transaction waits for IDLE.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
    tick(); tick();
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0100;
    run("late", 80, 2, 3, 1'b0, 1'b0, 1'b0);
    chk("late_cpu_ack", {ack_q[0].port, 16'(ack_q[0].cyc)}, {1'b0, 16'(LAT)});
    chk("late_dbg_ack", {ack_q[1].port, 16'(ack_q[1].cyc)}, {1'b1, 16'(2 * LAT + 3)});
    chk("late_dbg_en", {16'(en_q[0].cyc), en_q[0].addr}, {16'(LAT + 2), 16'h0100});
    chk("late_rdata", {cpu_rdata, dbg_rdata}, {16'h1234, 16'h2334});

    chk("mem_we_without_en", 64'(we_alone), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
